// File: rtl/spi_exe_master.sv
// SPI mode-0 master for the execute-unit slave: sends {argA, argB, oper}, then
// collects the 28-bit reply {result, flags, pad} and strobes o_valid.
module spi_exe_master #(
  parameter int unsigned CLK_DIV     = 2,
  parameter int unsigned TURN_CYCLES = 2,
  parameter int unsigned CS_GAP      = 4
) (
  input  logic       i_clk_p,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [7:0] i_argA,
  input  logic [7:0] i_argB,
  input  logic [7:0] i_oper,
  output logic       o_busy,
  output logic       o_sclk,
  output logic       o_cs_n,
  output logic       o_mosi,
  input  logic       i_miso,
  output logic [7:0] o_result,
  output logic [3:0] o_flags,
  output logic       o_err,
  output logic       o_valid
);

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    CMD,
    TURN,
    RSP,
    CS_HOLD,
    GAP
  } state_t;

  localparam logic [3:0] DIV_LAST  = 4'(CLK_DIV - 1);
  localparam logic [3:0] TURN_LAST = 4'(TURN_CYCLES - 1);
  localparam logic [3:0] GAP_LAST  = 4'(CS_GAP - 1);

  state_t      state;
  logic [3:0]  phase_cnt;
  logic [5:0]  bit_cnt;
  logic [3:0]  turn_cnt;
  logic [3:0]  gap_cnt;
  logic [22:0] cmd_sr;
  logic [27:0] rsp_sr;

  always_ff @(posedge i_clk_p or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      phase_cnt <= '0;
      bit_cnt   <= '0;
      turn_cnt  <= '0;
      gap_cnt   <= '0;
      cmd_sr    <= '0;
      rsp_sr    <= '0;
      o_busy    <= 1'b0;
      o_sclk    <= 1'b0;
      o_cs_n    <= 1'b1;
      o_mosi    <= 1'b0;
      o_result  <= '0;
      o_flags   <= '0;
      o_err     <= 1'b0;
      o_valid   <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_start) begin
            // o_mosi holds the command MSB; cmd_sr carries the remaining 23 bits
            o_mosi    <= i_argA[7];
            cmd_sr    <= {i_argA[6:0], i_argB, i_oper};
            o_busy    <= 1'b1;
            o_cs_n    <= 1'b0;
            phase_cnt <= '0;
            state     <= CS_SETUP;
          end
        end

        CS_SETUP: begin
          if (phase_cnt == DIV_LAST) begin
            phase_cnt <= '0;
            bit_cnt   <= '0;
            o_sclk    <= 1'b1;
            state     <= CMD;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end

        CMD, TURN, RSP: begin
          if (phase_cnt != DIV_LAST) begin
            phase_cnt <= phase_cnt + 1'b1;
          end else begin
            phase_cnt <= '0;
            if (o_sclk) begin
              // falling edge: advance MOSI, sample MISO
              o_sclk <= 1'b0;
              if (state == CMD) begin
                o_mosi <= cmd_sr[22];
                cmd_sr <= {cmd_sr[21:0], 1'b0};
              end
              if (state == RSP) begin
                rsp_sr <= {rsp_sr[26:0], i_miso};
              end
            end else begin
              // end of an SCLK cycle: count it and start the next one
              o_sclk <= 1'b1;
              if (state == CMD) begin
                if (bit_cnt == 6'd23) begin
                  bit_cnt  <= '0;
                  turn_cnt <= '0;
                  if (TURN_CYCLES == 0) begin
                    state <= RSP;
                  end else begin
                    state <= TURN;
                  end
                end else begin
                  bit_cnt <= bit_cnt + 1'b1;
                end
              end else if (state == TURN) begin
                if (turn_cnt == TURN_LAST) begin
                  state <= RSP;
                end else begin
                  turn_cnt <= turn_cnt + 1'b1;
                end
              end else begin
                if (bit_cnt == 6'd27) begin
                  o_sclk <= 1'b0;
                  state  <= CS_HOLD;
                end else begin
                  bit_cnt <= bit_cnt + 1'b1;
                end
              end
            end
          end
        end

        CS_HOLD: begin
          if (phase_cnt == DIV_LAST) begin
            o_cs_n   <= 1'b1;
            o_result <= rsp_sr[27:20];
            o_flags  <= rsp_sr[19:16];
            o_err    <= |rsp_sr[15:0];
            o_valid  <= 1'b1;
            gap_cnt  <= '0;
            state    <= GAP;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end

        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            o_busy <= 1'b0;
            state  <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_exe_master.sv
// Directed bench for spi_exe_master: default-parameter instance plus a
// fast back-to-back instance, each with a small execute-unit slave model.
module tb_spi_exe_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   cyc = 0;
  always @(posedge clk) cyc++;

  // default-parameter instance
  logic       start0, miso0, busy0, sclk0, cs_n0, mosi0, err0, valid0;
  logic [7:0] a0, b0, op0, res0;
  logic [3:0] flg0;

  // CLK_DIV=1, TURN_CYCLES=0, CS_GAP=1 instance
  logic       start1, miso1, busy1, sclk1, cs_n1, mosi1, err1, valid1;
  logic [7:0] a1, b1, op1, res1;
  logic [3:0] flg1;

  spi_exe_master u_dut (
    .i_clk_p(clk), .i_rst_n(rst_n), .i_start(start0),
    .i_argA(a0), .i_argB(b0), .i_oper(op0),
    .o_busy(busy0), .o_sclk(sclk0), .o_cs_n(cs_n0), .o_mosi(mosi0), .i_miso(miso0),
    .o_result(res0), .o_flags(flg0), .o_err(err0), .o_valid(valid0)
  );

  spi_exe_master #(.CLK_DIV(1), .TURN_CYCLES(0), .CS_GAP(1)) u_b2b (
    .i_clk_p(clk), .i_rst_n(rst_n), .i_start(start1),
    .i_argA(a1), .i_argB(b1), .i_oper(op1),
    .o_busy(busy1), .o_sclk(sclk1), .o_cs_n(cs_n1), .o_mosi(mosi1), .i_miso(miso1),
    .o_result(res1), .o_flags(flg1), .o_err(err1), .o_valid(valid1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // slave model / monitor for u_dut: response frame comes from rsp0
  logic [27:0] rsp0 = '0;
  logic [23:0] cmd0 = '0, last_cmd0 = '0;
  int rise0 = 0, last_rise0 = 0, vcnt0 = 0, t0_0 = 0, lat0 = 0, bfall0 = 0;
  logic cs_prev0 = 1'b1, sclk_prev0 = 1'b0, busy_prev0 = 1'b0;
  initial miso0 = 1'b0;

  always @(negedge clk) begin
    if (!cs_n0 && cs_prev0) begin rise0 = 0; cmd0 = '0; end
    if (cs_n0 && !cs_prev0) begin last_rise0 = rise0; last_cmd0 = cmd0; end
    if (!cs_n0 && sclk0 && !sclk_prev0) begin
      if (rise0 < 24) cmd0 = {cmd0[22:0], mosi0};
      if (rise0 >= 26 && rise0 < 54) miso0 = rsp0[53 - rise0];
      rise0++;
    end
    if (busy0 && !busy_prev0) t0_0 = cyc;
    if (!busy0 && busy_prev0) bfall0 = cyc + 1 - t0_0;
    if (valid0) begin vcnt0++; lat0 = cyc + 1 - t0_0; end
    cs_prev0 = cs_n0; sclk_prev0 = sclk0; busy_prev0 = busy0;
  end

  // slave model / monitor for u_b2b: result = A + B, flags = oper[7:4], pad = 0
  logic [27:0] rsp1 = '0;
  logic [23:0] cmd1 = '0;
  int rise1 = 0, t0_1 = 0, frames1 = 0, hcnt1 = 0, gap_min1 = 999;
  logic cs_prev1 = 1'b1, sclk_prev1 = 1'b0, busy_prev1 = 1'b0;
  int lat_q1[$];
  int rise_q1[$];
  logic [12:0] res_q1[$];
  initial miso1 = 1'b0;

  always @(negedge clk) begin
    if (!cs_n1 && cs_prev1) begin
      if (frames1 > 0 && hcnt1 < gap_min1) gap_min1 = hcnt1;
      rise1 = 0; cmd1 = '0;
    end
    if (cs_n1 && !cs_prev1) begin rise_q1.push_back(rise1); frames1++; hcnt1 = 0; end
    if (cs_n1) hcnt1++;
    if (!cs_n1 && sclk1 && !sclk_prev1) begin
      if (rise1 < 24) cmd1 = {cmd1[22:0], mosi1};
      if (rise1 == 23) rsp1 = {cmd1[23:16] + cmd1[15:8], cmd1[7:4], 16'h0000};
      if (rise1 >= 24 && rise1 < 52) miso1 = rsp1[51 - rise1];
      rise1++;
    end
    if (busy1 && !busy_prev1) t0_1 = cyc;
    if (valid1) begin
      lat_q1.push_back(cyc + 1 - t0_1);
      res_q1.push_back({res1, flg1, err1});
    end
    cs_prev1 = cs_n1; sclk_prev1 = sclk1; busy_prev1 = busy1;
  end

  task automatic drive_txn(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    @(negedge clk);
    a0 = a; b0 = b; op0 = op; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
  endtask

  task automatic wait_done0(input int v, input string tag);
    int k;
    k = 0;
    while (vcnt0 == v && k < 600) begin @(negedge clk); k++; end
    if (vcnt0 == v) check({tag, "_valid_timeout"}, 0, 1);
    k = 0;
    while (busy0 && k < 50) begin @(negedge clk); k++; end
    @(negedge clk);
  endtask

  task automatic wait_valid1();
    int k;
    k = 0;
    @(negedge clk);
    while (!valid1 && k < 300) begin @(negedge clk); k++; end
    if (!valid1) check("b2b_valid_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int v;
    int k;
    logic [12:0] exp_res[3];
    rst_n = 1'b0;
    start0 = 1'b0; a0 = '0; b0 = '0; op0 = '0;
    start1 = 1'b0; a1 = '0; b1 = '0; op1 = '0;
    #12;
    check("rst_busy",   busy0,  0);
    check("rst_cs_n",   cs_n0,  1);
    check("rst_sclk",   sclk0,  0);
    check("rst_mosi",   mosi0,  0);
    check("rst_result", res0,   0);
    check("rst_flags",  flg0,   0);
    check("rst_err",    err0,   0);
    check("rst_valid",  valid0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // asynchronous reset in the middle of the command phase
    rsp0 = {8'hFF, 4'hF, 16'h0000};
    v = vcnt0;
    drive_txn(8'hA5, 8'h5A, 8'h30);
    repeat (30) @(negedge clk);
    check("mid_cs_low", cs_n0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_cs_n",  cs_n0,  1);
    check("mid_rst_sclk",  sclk0,  0);
    check("mid_rst_busy",  busy0,  0);
    check("mid_rst_mosi",  mosi0,  0);
    check("mid_rst_valid", valid0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    check("mid_rst_no_valid", vcnt0 - v, 0);
    check("mid_rst_result", res0, 0);

    // nominal transaction
    rsp0 = {8'h46, 4'h0, 16'h0000};
    v = vcnt0;
    drive_txn(8'h12, 8'h34, 8'h10);
    wait_done0(v, "nom");
    check("nom_mosi_cmd", last_cmd0, 24'h123410);
    check("nom_latency",  lat0, 221);
    check("nom_busy_fall", bfall0, 225);
    check("nom_sclk_count", last_rise0, 54);
    check("nom_result", res0, 8'h46);
    check("nom_flags",  flg0, 4'h0);
    check("nom_err",    err0, 0);

    // flags and pad error
    rsp0 = {8'h80, 4'hA, 16'h0001};
    v = vcnt0;
    drive_txn(8'h7F, 8'h01, 8'h20);
    wait_done0(v, "flg");
    check("flg_mosi_cmd", last_cmd0, 24'h7F0120);
    check("flg_latency", lat0, 221);
    check("flg_result", res0, 8'h80);
    check("flg_flags",  flg0, 4'hA);
    check("flg_err",    err0, 1);

    // start pulse while busy must be ignored
    rsp0 = {8'h10, 4'h1, 16'h0000};
    v = vcnt0;
    drive_txn(8'h0F, 8'h01, 8'h10);
    @(negedge clk);
    k = 0;
    while (cyc < t0_0 + 49 && k < 100) begin @(negedge clk); k++; end
    a0 = 8'hAA; b0 = 8'hBB; op0 = 8'hCC; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_done0(v, "busy");
    repeat (20) @(negedge clk);
    check("busy_one_valid", vcnt0 - v, 1);
    check("busy_mosi_cmd", last_cmd0, 24'h0F0110);
    check("busy_latency", lat0, 221);
    check("busy_result", res0, 8'h10);
    check("busy_flags",  flg0, 4'h1);
    check("busy_err",    err0, 0);
    repeat (50) @(negedge clk);
    check("hold_result", res0, 8'h10);
    check("hold_busy", busy0, 0);

    // back-to-back frames with start held high
    a1 = 8'h01; b1 = 8'h02; op1 = 8'h10; start1 = 1'b1;
    wait_valid1();
    a1 = 8'h20; b1 = 8'h05; op1 = 8'h30;
    wait_valid1();
    a1 = 8'h7F; b1 = 8'h01; op1 = 8'h90;
    wait_valid1();
    start1 = 1'b0;
    repeat (150) @(negedge clk);
    exp_res[0] = {8'h03, 4'h1, 1'b0};
    exp_res[1] = {8'h25, 4'h3, 1'b0};
    exp_res[2] = {8'h80, 4'h9, 1'b0};
    check("b2b_frames", res_q1.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < res_q1.size()) check($sformatf("b2b_res%0d", i), res_q1[i], exp_res[i]);
      else check($sformatf("b2b_res%0d_missing", i), 0, 1);
      if (i < lat_q1.size()) check($sformatf("b2b_lat%0d", i), lat_q1[i], 107);
      else check($sformatf("b2b_lat%0d_missing", i), 0, 1);
      if (i < rise_q1.size()) check($sformatf("b2b_sclk%0d", i), rise_q1[i], 52);
      else check($sformatf("b2b_sclk%0d_missing", i), 0, 1);
    end
    check("b2b_cs_gap_min1", gap_min1 >= 1 && gap_min1 < 999, 1);
    check("b2b_idle_after", busy1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_exe_master.md
# spi_exe_master

SPI master that drives one arithmetic transaction into the SPI execute-unit slave and collects its reply. Accepts argA, argB and an opcode on a start/busy handshake, generates SCLK/CS/MOSI, shifts in the 28-bit response frame from MISO, and presents result, flags and a frame-error bit with a one-cycle valid strobe. It sits directly upstream of the execute-unit slave on the SPI link.

## Interface
- CLK_DIV, 2: SCLK half-period in i_clk_p cycles; legal range 1..15.
- TURN_CYCLES, 2: idle SCLK cycles between the command and response phases; legal range 0..15.
- CS_GAP, 4: minimum i_clk_p cycles o_cs_n stays high between frames; legal range 1..15.
- i_clk_p  in  1  system clock; every register updates on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_start  in  1  request a transaction; sampled only in IDLE.
- i_argA  in  8  operand A, captured when the start is accepted.
- i_argB  in  8  operand B, captured when the start is accepted.
- i_oper  in  8  opcode byte, captured when the start is accepted (the slave decodes bits [7:4]).
- o_busy  out  1  high from start acceptance to the end of the CS gap.
- o_sclk  out  1  SPI clock, mode 0 (idles low).
- o_cs_n  out  1  chip select, active low.
- o_mosi  out  1  serial command data, MSB first.
- i_miso  in  1  serial response data.
- o_result  out  8  received result byte.
- o_flags  out  4  received flags {BF, NF, OF, SF}.
- o_err  out  1  set when any of the 16 pad bits was non-zero.
- o_valid  out  1  one-cycle strobe; o_result, o_flags and o_err are new on this cycle.

## Operation
- States: IDLE, CS_SETUP, CMD, TURN, RSP, CS_HOLD, GAP.
- IDLE: o_busy=0, o_cs_n=1, o_sclk=0, o_mosi=0. If i_start=1 at an edge, latch {argA, argB, oper} into a 24-bit shift register and go to CS_SETUP.
- CS_SETUP: o_cs_n=0, o_sclk=0, o_mosi=argA[7]; lasts CLK_DIV cycles, then CMD.
- SCLK cycle: CLK_DIV cycles high, then CLK_DIV cycles low. Rising edges are the slave's sample points.
- CMD: 24 SCLK cycles. o_mosi shifts to the next bit on each SCLK falling edge. Order: argA[7:0], argB[7:0], oper[7:0].
- TURN: TURN_CYCLES SCLK cycles with o_mosi=0.
- RSP: 28 SCLK cycles with o_mosi=0. i_miso is sampled on the i_clk_p edge at which o_sclk goes high→low and shifted in MSB first. Frame order: result[7:0], flags[3:0], pad[15:0].
- CS_HOLD: o_sclk=0, o_cs_n=0 for CLK_DIV cycles.
- End of CS_HOLD, in the same cycle:
  - o_cs_n returns to 1.
  - o_result, o_flags and o_err (OR of the pad bits) are updated.
  - o_valid=1 for that cycle.
  - The FSM enters GAP.
- GAP: o_busy=1 for CS_GAP cycles, then IDLE.
- o_result, o_flags and o_err hold their values until the next o_valid.
- i_start is ignored while o_busy=1; no queuing.
- Input operands are captured only at acceptance; changing them mid-frame has no effect.
- Counters: SCLK-phase counter 4 bits; bit counter 6 bits (max 28); TURN and GAP counters 4 bits. No wrap-around is reachable within legal parameters.

## Timing
- Reset (asynchronous, any state): o_busy=0, o_cs_n=1, o_sclk=0, o_mosi=0, o_result=0, o_flags=0, o_err=0, o_valid=0, state=IDLE.
  - A reset mid-frame aborts the frame immediately; no o_valid is produced.
  - After reset release, the first start is accepted at the first edge with i_start=1.
- Start accepted at edge T0: o_busy=1 and o_cs_n=0 from T0+1.
- N_SCLK = 52 + TURN_CYCLES.
- o_valid asserts at cycle T0 + 1 + CLK_DIV + 2·CLK_DIV·N_SCLK + CLK_DIV. With defaults: T0+221.
- o_busy falls at o_valid + CS_GAP. The earliest next acceptance is on that cycle's edge.
- o_sclk, o_cs_n and o_mosi are driven directly from registers (glitch-free).

## Test plan
- Reset: assert i_rst_n=0 mid-CMD -> all outputs take reset values asynchronously; o_cs_n=1 and o_sclk=0 immediately; no o_valid is produced.
- Nominal transaction, default parameters: argA=0x12, argB=0x34, oper=0x10; the slave model returns result=0x46, flags=0x0, pad=0.
  - MOSI sampled at SCLK rising edges reads 0x123410.
  - o_valid at T0+221 with o_result=0x46, o_flags=0x0, o_err=0.
- Flags and pad error: the model returns result=0x80, flags=0b1010, and pad bit 0 =1 -> o_result=0x80, o_flags=0xA, o_err=1.
- Start while busy: pulse i_start at T0+50 with different operands -> ignored; the frame is unchanged and exactly one o_valid is produced.
- Back-to-back frames, CLK_DIV=1, TURN_CYCLES=0, CS_GAP=1, i_start held high:
  - Each frame is 52 SCLK cycles.
  - o_cs_n is high for at least 1 cycle between frames.
  - Each o_valid is at T0+1+1+104+1=T0+107.
  - Operand changes between frames are reflected in the next frame.
